// File: rtl/led_switch_logic.sv
`default_nettype none
// led_switch_logic: per-channel synchronise + debounce of slide switches, reduced
// to a registered LED drive by a run-time selectable AND / OR / XOR / majority.
module led_switch_logic #(
  parameter int N_SWITCHES      = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SWITCHES-1:0] switches,
  input  logic [1:0]            mode,
  output logic [N_SWITCHES-1:0] debounced,
  output logic                  led,
  output logic                  led_changed
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [1:0] c_mode_and = 2'b00;
  localparam logic [1:0] c_mode_or  = 2'b01;
  localparam logic [1:0] c_mode_xor = 2'b10;

  genvar i;
  for (i = 0; i < N_SWITCHES; i++) begin : g_chan
    logic               sync1_q;
    logic               sync2_q;
    logic               deb_q;
    logic               deb_d;
    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Any cycle where the synchronised level agrees with the accepted one
    // restarts the count, so only an unbroken mismatch run is accepted.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == c_cnt_last) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= switches[i];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end

    assign debounced[i] = deb_q;
  end

  logic [1:0]  mode_q;
  logic        led_q;
  logic        led_d;
  logic        led_changed_q;
  logic [31:0] ones;

  always_comb begin
    ones = '0;
    for (int k = 0; k < N_SWITCHES; k++) begin
      ones = ones + 32'(debounced[k]);
    end
    case (mode_q)
      c_mode_and: led_d = &debounced;
      c_mode_or:  led_d = |debounced;
      c_mode_xor: led_d = ^debounced;
      // Strict majority: an even-count tie drives 0.
      default:    led_d = (ones > 32'(N_SWITCHES / 2));
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= 2'b00;
      led_q         <= 1'b0;
      led_changed_q <= 1'b0;
    end else begin
      mode_q        <= mode;
      led_q         <= led_d;
      led_changed_q <= (led_d != led_q);
    end
  end

  assign led         = led_q;
  assign led_changed = led_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_led_switch_logic.sv
`default_nettype none
// tb_led_switch_logic: directed test-plan scenarios plus randomised traffic,
// checked every cycle against a history-window reference model.
module tb_led_switch_logic;

  localparam int N  = 3;
  localparam int DC = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] switches;
  logic [1:0]   mode;
  logic [N-1:0] debounced;
  logic         led;
  logic         led_changed;

  led_switch_logic #(
    .N_SWITCHES     (N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .switches   (switches),
    .mode       (mode),
    .debounced  (debounced),
    .led        (led),
    .led_changed(led_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a channel flips once its last DC synchronised samples
  // all disagree with the accepted value.
  logic [N-1:0] m_s1, m_s2, m_deb;
  logic         m_hist [N][DC];
  logic [1:0]   m_mode_q;
  logic         m_led, m_chg;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    m_mode_q = 2'b00; m_led = 1'b0; m_chg = 1'b0;
    for (int c = 0; c < N; c++)
      for (int j = 0; j < DC; j++) m_hist[c][j] = 1'b0;
  endtask

  task automatic model_edge();
    int           ones;
    logic         nl;
    logic         all_diff;
    logic [N-1:0] nd;
    if (!reset) begin
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(m_deb[k]);
      case (m_mode_q)
        2'd0:    nl = (ones == N);
        2'd1:    nl = (ones > 0);
        2'd2:    nl = (ones % 2 == 1);
        default: nl = (2 * ones > N);
      endcase
      for (int c = 0; c < N; c++) begin
        for (int j = 0; j < DC - 1; j++) m_hist[c][j] = m_hist[c][j+1];
        m_hist[c][DC-1] = m_s2[c];
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++) if (m_hist[c][j] == m_deb[c]) all_diff = 1'b0;
        nd[c] = all_diff ? ~m_deb[c] : m_deb[c];
      end
      m_chg    = (nl != m_led);
      m_led    = nl;
      m_deb    = nd;
      m_mode_q = mode;
      m_s2     = m_s1;
      m_s1     = switches;
    end
  endtask

  task automatic compare_all();
    chk("debounced", 32'(debounced), 32'(m_deb));
    chk("led", 32'(led), 32'(m_led));
    chk("led_changed", 32'(led_changed), 32'(m_chg));
  endtask

  task automatic step(input int n = 1);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic async_reset_now();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_deb", 32'(debounced), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_chg", 32'(led_changed), 32'h0);
  endtask

  int mode_tbl [4] = '{1, 2, 3, 0};
  int led_tbl  [4] = '{1, 0, 1, 0};

  initial begin
    reset    = 1'b1;
    switches = '0;
    mode     = 2'b00;
    model_reset();
    #12;
    reset = 1'b0;
    step(3);

    // Reset: bring led high, then assert reset mid-cycle.
    switches = 3'b111;
    step(9);
    chk("pre_rst_led", 32'(led), 32'h1);
    async_reset_now();
    switches = 3'b000;
    step(2);
    #3 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_chg", 32'(led_changed), 32'h0);
    end

    // Clean AND.
    mode = 2'b00;
    switches = 3'b111;
    step(5);
    chk("and_deb_e4", 32'(debounced), 32'h0);
    step();
    chk("and_deb_e5", 32'(debounced), 32'h7);
    step();
    chk("and_led_e6", 32'(led), 32'h1);
    chk("and_chg_e6", 32'(led_changed), 32'h1);
    step();
    chk("and_chg_e7", 32'(led_changed), 32'h0);
    switches = 3'b011;
    step(6);
    chk("and_fall_e5", 32'(led), 32'h1);
    step();
    chk("and_fall_e6", 32'(led), 32'h0);

    // Bounce rejection on switch 0.
    switches = 3'b000;
    step(10);
    for (int r = 0; r < 5; r++) begin
      switches = 3'b001;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("bounce_deb", 32'(debounced), 32'h0);
        chk("bounce_chg", 32'(led_changed), 32'h0);
      end
      switches = 3'b000;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("bounce_deb", 32'(debounced), 32'h0);
      end
    end
    switches = 3'b001;
    step(5);
    chk("bounce_acc_e4", 32'(debounced), 32'h0);
    step();
    chk("bounce_acc_e5", 32'(debounced), 32'h1);

    // Mode sweep with debounced = 110.
    switches = 3'b110;
    step(8);
    chk("sweep_deb", 32'(debounced), 32'h6);
    chk("sweep_led0", 32'(led), 32'h0);
    for (int m = 0; m < 4; m++) begin
      mode = mode_tbl[m][1:0];
      step();
      chk("sweep_hold", 32'(led), 32'(led_tbl[(m + 3) % 4]));
      step();
      chk("sweep_led", 32'(led), 32'(led_tbl[m]));
      chk("sweep_chg", 32'(led_changed), 32'h1);
      step();
      chk("sweep_chg_off", 32'(led_changed), 32'h0);
    end

    // Independent channels under XOR.
    mode = 2'b10;
    switches = 3'b000;
    step(10);
    switches = 3'b001;
    for (int k = 0; k <= 10; k++) begin
      if (k == 2) switches = 3'b101;
      step();
      chk("indep_deb", 32'(debounced), (k < 5) ? 32'h0 : (k < 7) ? 32'h1 : 32'h5);
      chk("indep_led", 32'(led), (k >= 6 && k < 8) ? 32'h1 : 32'h0);
      chk("indep_chg", 32'(led_changed), (k == 6 || k == 8) ? 32'h1 : 32'h0);
    end

    // Reset mid-debounce (count at 2) discards the partial count.
    switches = 3'b000;
    step(10);
    switches = 3'b001;
    step(4);
    async_reset_now();
    step(2);
    #3 reset = 1'b0;
    step(5);
    chk("rst_mid_e4", 32'(debounced), 32'h0);
    step();
    chk("rst_mid_e5", 32'(debounced), 32'h1);

    // Randomised traffic: sparse toggles so some runs survive the filter.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) switches[b] = ~switches[b];
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        async_reset_now();
        step();
        #3 reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_switch_logic.md
# led_switch_logic

Parametrised switch-to-LED logic block: N_SWITCHES asynchronous slide switches are synchronised and debounced per channel. The stable values are then reduced to a single LED drive by a run-time selectable function: AND, OR, XOR parity or majority. It is the next-generation replacement for the two-switch AND LED block and sits directly between board switch pins and an LED pin. It also exports the debounced switch vector and a one-cycle LED-change pulse for other logic.

## Interface
- N_SWITCHES, 2, number of switch channels; legal range ≥ 1.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised switch value must differ from the current debounced value before it is accepted; legal range ≥ 1. Counter width is $clog2(DEBOUNCE_CYCLES)+1.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset; one clock, no other clock domains.
- switches  input  N_SWITCHES  raw asynchronous switch levels.
- mode  input  2  reduction select: 00 AND, 01 OR, 10 XOR (odd parity), 11 majority.
- debounced  output  N_SWITCHES  current accepted switch values.
- led  output  1  registered LED drive.
- led_changed  output  1  one-cycle pulse in the cycle after led changes value.

## Operation
- Per channel, 2-flop synchroniser: sync1 <= switches[i]; sync2 <= sync1.
- Per channel, debounce counter cnt[i]:
  - sync2 == debounced[i]: cnt <= 0.
  - sync2 != debounced[i] and cnt == DEBOUNCE_CYCLES-1: debounced[i] <= sync2, cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
- A mismatch lasting fewer than DEBOUNCE_CYCLES cycles (bounce/glitch) returns cnt to 0 and never alters debounced.
- Channels are fully independent; simultaneous transitions on several channels are each debounced separately.
- mode is registered into mode_q every cycle; reduction uses mode_q only.
- Reduction over debounced:
  - AND: all ones.
  - OR: any one.
  - XOR: odd number of ones.
  - Majority: popcount > N_SWITCHES/2, strictly. An even-N tie gives 0. With N_SWITCHES = 1, majority equals the single bit.
- led <= reduction result every cycle.
- led_changed <= (new led value != old led value), registered alongside led. It is high exactly one cycle per transition.
- Reset values, all applied immediately and asynchronously:
  - Synchroniser flops 0.
  - cnt 0.
  - debounced all 0.
  - mode_q 00.
  - led 0.
  - led_changed 0.
- After reset the block is in steady state with every channel accepted as 0. No spurious led_changed pulse occurs on reset release.
- Reset asserted mid-debounce discards partial counts; counting restarts from 0 after release.

## Timing
- Edge numbering: edge 0 is the first rising edge sampling a new stable switch level.
- sync2 updates at edge 1.
- Counting runs over edges 2 … DEBOUNCE_CYCLES.
- debounced[i] updates at edge DEBOUNCE_CYCLES+1.
- led updates at edge DEBOUNCE_CYCLES+2. Total input-to-LED latency is DEBOUNCE_CYCLES+3 edges.
- led_changed is high in the cycle following edge DEBOUNCE_CYCLES+2, i.e. coincident with the new led value for one cycle.
- mode change before edge 0: mode_q at edge 0, led at edge 1 (2-edge latency). Any resulting led_changed pulse follows the same rule.
- No combinational path from any input to any output.

## Test plan
- Parameters for all scenarios: N_SWITCHES=3, DEBOUNCE_CYCLES=4.
- Reset: assert reset mid-cycle with switches=111 and mode=00 -> all outputs 0 immediately. After release, led=0 and no led_changed pulse.
- Clean AND: mode=00; switches 000→111 stable -> debounced=111 at edge 5, led=1 at edge 6, led_changed high for exactly one cycle. Then switches=011 -> led returns to 0 seven edges later.
- Bounce rejection: switch 0 toggles 0→1 for 3 cycles then back to 0, repeated 5 times -> debounced stays 000, led stays 0, no led_changed. A fourth cycle of stable 1 is accepted at the normal latency.
- Mode sweep with debounced=110:
  - OR -> led=1.
  - XOR -> led=0.
  - Majority -> led=1.
  - AND -> led=0.
  - Each change is visible 2 edges after the mode change, with one led_changed pulse per led toggle.
- Simultaneous and independent channels: switch 0 rises at cycle 0 and switch 2 rises at cycle 2 -> debounced bits update at edges 5 and 7 respectively. XOR led goes 0→1→0 with two separate pulses.
- Reset mid-operation: assert reset when cnt=2 on a rising channel -> debounced stays 0. After release with the input held at 1, acceptance takes the full DEBOUNCE_CYCLES+2 edges from release.
